// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types plus the hazard-scoreboard additions (state enum, shadow entry).
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  typedef struct packed {
    opcode_t    opcode;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_t;

  typedef struct packed {
    opcode_t     opcode;
    regbits_t    rs;
    regbits_t    rt;
    logic [15:0] imm;
  } i_t;

  typedef enum logic [1:0] {RUN, WAIT, LDSTALL} hz_state_t;

  typedef struct packed {
    logic     valid;
    regbits_t dest;
    logic     is_load;
    logic     is_mem;
  } shadow_t;

  localparam regbits_t REG_RA = 5'd31;

endpackage

// File: rtl/hazard_scoreboard_dest_decode.sv
// Combinational decode of an instruction into its destination record and source-register usage.
module dest_decode
  import cpu_types_pkg::*;
(
  input  word_t   instr,
  output shadow_t dec,
  output logic    rs_used,
  output logic    rt_used
);

  r_t   r;
  logic unused_shamt;

  assign r            = r_t'(instr);
  assign unused_shamt = ^r.shamt;

  always_comb begin
    dec     = '0;
    rs_used = 1'b1;
    rt_used = 1'b0;
    case (r.opcode)
      RTYPE: begin
        rt_used = 1'b1;
        if (r.funct != FUNCT_JR) dec.dest = r.rd;
      end
      JAL: begin
        rs_used  = 1'b0;
        dec.dest = REG_RA;
      end
      J: rs_used = 1'b0;
      LW: begin
        dec.dest    = r.rt;
        dec.is_load = 1'b1;
        dec.is_mem  = 1'b1;
      end
      SW: begin
        rt_used    = 1'b1;
        dec.is_mem = 1'b1;
      end
      BEQ, BNE: rt_used = 1'b1;
      ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: dec.dest = r.rt;
      default: ;
    endcase
    // Writes to $0 are architecturally discarded, so they never create a hazard.
    dec.valid = (dec.dest != '0);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard control: shadow dest tracking, load-use stall, memory wait, redirect flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t instr_ID,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  redirect_EX,
  output logic  pc_en,
  output logic  ifid_en,
  output logic  idex_en,
  output logic  exmem_en,
  output logic  memwb_en,
  output logic  ifid_flush,
  output logic  idex_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  hz_state_t state, state_next;
  shadow_t   shadow_ex_p0, shadow_mem_p1, shadow_wb_p2;
  shadow_t   dec;
  r_t        instr_r;
  logic      rs_used, rt_used;
  logic      redir_pend, redir, advance, load_use;
  logic      unused_shadow;

  dest_decode u_dest_decode (
    .instr   (instr_ID),
    .dec     (dec),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  assign instr_r  = r_t'(instr_ID);
  assign advance  = shadow_mem_p1.is_mem ? dhit : ihit;
  assign redir    = redirect_EX | redir_pend;
  assign load_use = shadow_ex_p0.valid & shadow_ex_p0.is_load &
                    ((rs_used & (shadow_ex_p0.dest == instr_r.rs)) |
                     (rt_used & (shadow_ex_p0.dest == instr_r.rt)));

  // WB entry and MEM destination are recorded for bypass bookkeeping but do not gate control here.
  assign unused_shadow = ^{shadow_wb_p2, shadow_mem_p1.valid, shadow_mem_p1.dest,
                           shadow_mem_p1.is_load};

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (advance) begin
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (redir) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LDSTALL: if (advance) state_next = RUN;
      default: begin
        if (!advance)                  state_next = WAIT;
        else if (load_use && !redir)   state_next = LDSTALL;
        else                           state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      redir_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (advance)          redir_pend <= 1'b0;
      else if (redirect_EX) redir_pend <= 1'b1;
    end
  end

  // Shadow pipeline: ID -> EX -> MEM -> WB, moving only on advancing cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shadow_ex_p0  <= '0;
      shadow_mem_p1 <= '0;
      shadow_wb_p2  <= '0;
    end else if (advance) begin
      shadow_wb_p2  <= shadow_mem_p1;
      shadow_mem_p1 <= shadow_ex_p0;
      shadow_ex_p0  <= idex_flush ? '0 : dec;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)            stall_cnt <= stall_cnt + PERF_W'(1);
      if (advance && redir)  flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`else
  logic [PERF_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule
